// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port and packed word stream bundle for fifo_rd_packer
// Purpose: groups the FIFO show-ahead read port, the flush request and the packed
//          valid/ready output of fifo_rd_packer into one interface.
// Signals:
//   fifo_data  [IN_WIDTH]            FIFO head entry, valid when fifo_empty=0
//   fifo_empty                       FIFO empty flag
//   fifo_rd_en                       pop request (driven by the packer)
//   flush                            single-cycle partial-word flush request
//   out_data   [IN_WIDTH*OUT_BYTES]  packed word, byte 0 in the LSBs
//   out_keep   [OUT_BYTES]           per-lane valid mask
//   out_valid / out_ready            output handshake
// Modports: master = packer side, slave = FIFO/downstream side.
interface fifo_rd_packer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_BYTES = 4
);
  logic [IN_WIDTH-1:0]           fifo_data;
  logic                          fifo_empty;
  logic                          fifo_rd_en;
  logic                          flush;
  logic [IN_WIDTH*OUT_BYTES-1:0] out_data;
  logic [OUT_BYTES-1:0]          out_keep;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    input  fifo_data, fifo_empty, flush, out_ready,
    output fifo_rd_en, out_data, out_keep, out_valid
  );

  modport slave (
    output fifo_data, fifo_empty, flush, out_ready,
    input  fifo_rd_en, out_data, out_keep, out_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs show-ahead FIFO bytes little-endian into wide words
// Purpose: pops entries from the async FIFO read port, packs OUT_BYTES of them into
//          one word (lane 0 in the LSBs) and presents it on a valid/ready output
//          with a keep mask; partial words leave on flush.
// Ports:
//   rd_clk  read-domain clock
//   rd_rst  synchronous active-high reset
//   bus     fifo_rd_packer_if.master (fifo_data/fifo_empty/fifo_rd_en, flush,
//           out_data/out_keep/out_valid/out_ready)
// Optional: define PACKER_TIMEOUT_EN to auto-flush a partial word after TIMEOUT
//           idle cycles.
module fifo_rd_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_BYTES = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  fifo_rd_packer_if.master bus
);
  localparam int CW = $clog2(OUT_BYTES + 1);
  localparam int LW = $clog2(OUT_BYTES);
  localparam int DW = IN_WIDTH * OUT_BYTES;

  logic [DW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [OUT_BYTES-1:0] out_keep_q, out_keep_d;
  logic                 out_valid_q, out_valid_d;

  logic                 out_free, xfer_full, xfer_flush, pop, timeout_hit;
  logic [LW-1:0]        lane;
  logic [OUT_BYTES-1:0] keep_part;

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;

  // Idle cycles with a partial word held; reaching TIMEOUT requests a flush.
  always_comb begin
    idle_d      = idle_q;
    timeout_hit = 1'b0;
    if (pop || cnt_q == '0) begin
      idle_d = '0;
    end else if (idle_q == TW'(TIMEOUT)) begin
      idle_d      = '0;
      timeout_hit = 1'b1;
    end else if (!flush_pend_q) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    out_free   = !out_valid_q || bus.out_ready;
    xfer_full  = (cnt_q == CW'(OUT_BYTES)) && out_free;
    xfer_flush = flush_pend_q && (cnt_q != '0) && (cnt_q < CW'(OUT_BYTES)) && out_free;
    // A pending or arriving flush freezes popping so the partial word is well defined.
    pop = !rd_rst && !bus.fifo_empty && !flush_pend_q && !bus.flush &&
          ((cnt_q < CW'(OUT_BYTES)) || xfer_full);
    // When the full word leaves this cycle the incoming byte starts a new word.
    lane = xfer_full ? '0 : cnt_q[LW-1:0];

    for (int i = 0; i < OUT_BYTES; i++) begin
      keep_part[i] = (CW'(i) < cnt_q);
    end

    // Accumulator is zeroed on every transfer so unfilled lanes of a flush read as 0.
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (xfer_full || xfer_flush) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (pop) begin
      acc_d[lane*IN_WIDTH +: IN_WIDTH] = bus.fifo_data;
      cnt_d = cnt_d + 1'b1;
    end

    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    if (xfer_full) begin
      out_data_d  = acc_q;
      out_keep_d  = '1;
      out_valid_d = 1'b1;
    end else if (xfer_flush) begin
      out_data_d  = acc_q;
      out_keep_d  = keep_part;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // With a full accumulator the flag survives until the word has left.
    flush_pend_d = flush_pend_q;
    if (xfer_flush || (flush_pend_q && cnt_q == '0)) flush_pend_d = 1'b0;
    if (timeout_hit || bus.flush)                     flush_pend_d = 1'b1;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.out_data   = out_data_q;
  assign bus.out_keep   = out_keep_q;
  assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;
  localparam int OB = 4;
  localparam int T  = 64;

  logic rd_clk = 1'b0;
  logic rd_rst;
  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer_if #(.IN_WIDTH(8), .OUT_BYTES(OB)) ifc ();

  fifo_rd_packer #(.IN_WIDTH(8), .OUT_BYTES(OB), .TIMEOUT(T)) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (ifc)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  src_q[$];
  logic [31:0] cap_data[$];
  logic [3:0]  cap_keep[$];
  int pops, run, max_run, valid_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cap_d(input int i);
    return (i < cap_data.size()) ? cap_data[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] cap_k(input int i);
    return (i < cap_keep.size()) ? {28'h0, cap_keep[i]} : 32'hxxxxxxxx;
  endfunction

  task automatic drive_fifo();
    ifc.fifo_empty = (src_q.size() == 0);
    ifc.fifo_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    src_q.push_back(b);
    drive_fifo();
  endtask

  task automatic clear_stats();
    pops = 0; run = 0; max_run = 0; valid_cycles = 0;
    cap_data.delete();
    cap_keep.delete();
  endtask

  // One clock: sample at the falling edge, let the rising edge act, then update the FIFO model.
  task automatic tick();
    logic p;
    @(negedge rd_clk);
    p = ifc.fifo_rd_en;
    if (p) begin
      pops++; run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (ifc.out_valid) valid_cycles++;
    if (ifc.out_valid && ifc.out_ready) begin
      cap_data.push_back(ifc.out_data);
      cap_keep.push_back(ifc.out_keep);
    end
    @(posedge rd_clk);
    #1;
    if (p) void'(src_q.pop_front());
    drive_fifo();
  endtask

  initial begin
    rd_rst        = 1'b1;
    ifc.flush     = 1'b0;
    ifc.out_ready = 1'b1;
    clear_stats();
    push(8'h55);

    // 1: reset with a non-empty FIFO
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_rd_en", ifc.fifo_rd_en, 0);
      check("rst_valid", ifc.out_valid, 0);
      check("rst_keep", ifc.out_keep, 0);
      check("rst_data", ifc.out_data, 0);
    end
    check("rst_pops", pops, 0);
    src_q.delete();
    drive_fifo();
    rd_rst = 1'b0;

    // 2: back-to-back bytes 01..08
    clear_stats();
    for (int b = 1; b <= 8; b++) push(8'(b));
    repeat (5) tick();
    check("lat_valid", ifc.out_valid, 1);
    check("lat_data", ifc.out_data, 32'h04030201);
    repeat (5) tick();
    check("bb_pops", pops, 8);
    check("bb_run", max_run, 8);
    check("bb_words", cap_data.size(), 2);
    check("bb_w0", cap_d(0), 32'h04030201);
    check("bb_k0", cap_k(0), 32'hF);
    check("bb_w1", cap_d(1), 32'h08070605);
    check("bb_k1", cap_k(1), 32'hF);

    // 3: backpressure with 12 bytes 10..1B
    clear_stats();
    ifc.out_ready = 1'b0;
    for (int b = 8'h10; b <= 8'h1B; b++) push(8'(b));
    repeat (10) tick();
    check("bp_valid", ifc.out_valid, 1);
    check("bp_data_a", ifc.out_data, 32'h13121110);
    repeat (10) tick();
    check("bp_pops", pops, 8);
    check("bp_rd_en", ifc.fifo_rd_en, 0);
    check("bp_data_b", ifc.out_data, 32'h13121110);
    check("bp_keep", ifc.out_keep, 32'hF);
    check("bp_nocap", cap_data.size(), 0);
    clear_stats();
    ifc.out_ready = 1'b1;
    repeat (12) tick();
    check("bp_words", cap_data.size(), 3);
    check("bp_w0", cap_d(0), 32'h13121110);
    check("bp_w1", cap_d(1), 32'h17161514);
    check("bp_w2", cap_d(2), 32'h1B1A1918);
    check("bp_pops2", pops, 4);

    // 4: partial word via flush, then flush with nothing held
    clear_stats();
    push(8'hAA);
    push(8'hBB);
    repeat (3) tick();
    check("fl_pops", pops, 2);
    check("fl_pre_valid", valid_cycles, 0);
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    repeat (4) tick();
    check("fl_words", cap_data.size(), 1);
    check("fl_w0", cap_d(0), 32'h0000BBAA);
    check("fl_k0", cap_k(0), 32'h3);
    clear_stats();
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    repeat (4) tick();
    check("fl_empty_valid", valid_cycles, 0);

    // 5: reset discards a partial word
    clear_stats();
    push(8'h01); push(8'h02); push(8'h03);
    repeat (4) tick();
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    check("r5_valid", ifc.out_valid, 0);
    for (int b = 8'h11; b <= 8'h14; b++) push(8'(b));
    repeat (8) tick();
    check("r5_words", cap_data.size(), 1);
    check("r5_w0", cap_d(0), 32'h14131211);
    check("r5_k0", cap_k(0), 32'hF);

    // 6: single byte with no flush
    clear_stats();
    push(8'h5A);
    tick();
    check("to_pops", pops, 1);
`ifdef PACKER_TIMEOUT_EN
    repeat (T + 3) tick();
    check("to_words", cap_data.size(), 1);
    check("to_w0", cap_d(0), 32'h0000005A);
    check("to_k0", cap_k(0), 32'h1);
`else
    repeat (200) tick();
    check("to_none", valid_cycles, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
